// File: rtl/vx_stream_rr_arbiter.sv
// vx_stream_rr_arbiter
// Round-robin arbiter that merges NUM_REQS valid/ready producer streams onto
// one fully registered output stage. The winner's index travels with the
// payload on sel_out so downstream logic can route responses back.
module vx_stream_rr_arbiter #(
    parameter int  NUM_REQS = 4,
    parameter int  DATAW    = 32,
    localparam int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       valid_in,
    output logic [NUM_REQS-1:0]       ready_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SELW-1:0]           sel_out,
    input  logic                      ready_out
);

    // Index of the most recently accepted requester; the search for the next
    // winner starts one above it, which gives the round-robin rotation.
    logic [SELW-1:0]     last;
    logic                stall;
    logic                found;
    logic [SELW-1:0]     win_idx;
    logic [DATAW-1:0]    win_data;
    logic [NUM_REQS-1:0] grant;

    // The output register cannot accept while it holds an unconsumed payload.
    assign stall = valid_out & ~ready_out;

    // Grant is masked by reset_n so nothing is accepted while reset is held,
    // and by stall so no arbitration state moves during backpressure.
    assign ready_in = grant & {NUM_REQS{~stall & reset_n}};

    // Pick the first valid requester at or after last+1, wrapping modulo NUM_REQS.
    always_comb begin
        int idx;
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        idx      = 0;
        grant    = '0;
        found    = 1'b0;
        win_idx  = '0;
        win_data = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            idx = (int'(last) + k) % NUM_REQS;
            if (!found && valid_in[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = SELW'(idx);
                win_data   = data_in[idx*DATAW +: DATAW];
            end
        end
    end

    // Output register and priority pointer: load on ~stall, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            valid_out <= 1'b0;
            data_out  <= '0;
            sel_out   <= '0;
            // Starting at NUM_REQS-1 gives requester 0 top priority after reset.
            last      <= SELW'(NUM_REQS - 1);
        end else if (!stall) begin
            valid_out <= found;
            // With no valid requester the payload fields keep their old
            // contents; only valid_out drops, creating a bubble.
            if (found) begin
                data_out <= win_data;
                sel_out  <= win_idx;
                last     <= win_idx;
            end
        end
    end

endmodule
